pulse_scheduler: RTL and testbench
==================================

PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, giving the width of the phase counter and all phase/offset fields.
REQ-002 The block SHALL have parameter FCNT_W, default 8, giving the width of the completed-frame counter.
REQ-003 The block SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port start  in  1  one-cycle request to begin framing.
REQ-006 The block SHALL have port stop  in  1  one-cycle request to halt at the end of the current frame.
REQ-007 The block SHALL have port single  in  1  sampled with start; 1 means run exactly one frame.
REQ-008 The block SHALL have port cfg_valid  in  1  configuration write request.
REQ-009 The block SHALL have port cfg_ready  out  1  configuration write accepted when high with cfg_valid.
REQ-010 The block SHALL have port cfg_addr  in  2  register select: 0 = LAST, 1 = DATA_OFS, 2 = SET_OFS, 3 = STATE_OFS.
REQ-011 The block SHALL have port cfg_data  in  CNT_W  value to write.
REQ-012 The block SHALL have port Data_Out_pulse  out  1  data-output phase pulse.
REQ-013 The block SHALL have port Set_Data_out_pulse  out  1  set-data phase pulse.
REQ-014 The block SHALL have port State_Out_pulse  out  1  state-output phase pulse.
REQ-015 The block SHALL have port frame_start  out  1  high in every cycle where phase = 0 while running.
REQ-016 The block SHALL have port busy  out  1  high in RUN and STOP_PEND.
REQ-017 The block SHALL have port frame_count  out  FCNT_W  number of completed frames, wrapping.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and STOP_PEND.
REQ-019 In IDLE, start=1 with stop=0 SHALL clear phase to 0 and enter RUN next cycle, latching single into a one-shot flag.
REQ-020 In IDLE, start=1 with stop=1 SHALL be ignored (stop wins), staying in IDLE.
REQ-021 In RUN, phase SHALL increment by 1 per cycle and wrap from active LAST to 0.
REQ-022 In RUN, stop=1 or a set one-shot flag SHALL move the FSM to STOP_PEND, with phase continuing to advance.
REQ-023 In STOP_PEND, the wrap at phase = LAST SHALL go to IDLE with phase held at 0.
REQ-024 In STOP_PEND, start=1 SHALL cancel the stop, return the FSM to RUN and clear the one-shot flag.
REQ-025 Each pulse output SHALL be high for exactly the one cycle per frame in which busy=1 and phase equals its active offset.
REQ-026 Any offset greater than active LAST SHALL produce no pulse.
REQ-027 Equal offsets SHALL assert their pulses in the same cycle.
REQ-028 All pulse outputs and frame_start SHALL be 0 in IDLE.
REQ-029 frame_count SHALL increment by 1 on every wrap from LAST in RUN or STOP_PEND, wrapping from all-ones to 0 without saturating.
REQ-030 Configuration SHALL be held in shadow and active register sets; pulse decode SHALL use only the active set.
REQ-031 A cfg_valid and cfg_ready handshake SHALL write cfg_data into the shadow register selected by cfg_addr.
REQ-032 In IDLE, shadow SHALL be copied to active every cycle, so an IDLE write takes effect one cycle later.
REQ-033 In RUN and STOP_PEND, shadow SHALL be copied to active only on the wrap edge, so the next frame uses the new values.
REQ-034 cfg_ready SHALL be 1 except in the commit cycle (busy=1 and phase = LAST), where it SHALL be 0; writes are never lost or torn mid-frame.
REQ-035 A LAST value of 0 SHALL be stored as 1, giving a minimum frame of 2 cycles.

Reset
REQ-036 Synchronous rst=1 SHALL force IDLE, phase=0, frame_count=0, one-shot flag cleared, all pulses, frame_start and busy = 0, and cfg_ready=1.
REQ-037 Reset SHALL load shadow and active registers with LAST=10, DATA_OFS=2, SET_OFS=4, STATE_OFS=6.
REQ-038 Reset asserted mid-frame SHALL abort the frame with no further pulses, and rst SHALL take priority over start, stop and cfg_valid.

Verification
REQ-039 Reset then start=1 (single=0), running 33 cycles -> frame period 11; Data_Out_pulse at phase 2, Set_Data_out_pulse at 4, State_Out_pulse at 6; frame_count=3.
REQ-040 Start with single=1 -> exactly one frame of 11 cycles with one pulse each, then IDLE with busy=0 and frame_count=1.
REQ-041 Mid-frame (phase 3) write LAST=5 -> current frame still ends at phase 10; next frame period is 6.
REQ-042 Write issued in the commit cycle -> cfg_ready=0 and the write is accepted the next cycle.
REQ-043 Stop at phase 4 followed by start at phase 8 -> framing continues with no gap.
REQ-044 Write STATE_OFS=12 with LAST=10 -> State_Out_pulse never asserts; LAST=0 written -> period 2.

Source files
------------

// File: rtl/pulse_scheduler_if.sv
// pulse_scheduler_if: configuration write bus for pulse_scheduler.
//   cfg_valid : write request (master -> slave)
//   cfg_ready : write accepted when high with cfg_valid (slave -> master)
//   cfg_addr  : register select 0=LAST 1=DATA_OFS 2=SET_OFS 3=STATE_OFS
//   cfg_data  : value to write, CNT_W bits
interface pulse_scheduler_if #(
    parameter int CNT_W = 4
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_data;
    modport master (output cfg_valid, cfg_addr, cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, cfg_addr, cfg_data, output cfg_ready);
endinterface

// File: rtl/pulse_scheduler.sv
// pulse_scheduler: frame phase counter emitting three programmable phase pulses.
//   clk, rst            : clock, synchronous active-high reset
//   start, stop, single : framing control (single sampled with start)
//   cfg                 : configuration write bus (slave side)
//   Data_Out_pulse, Set_Data_out_pulse, State_Out_pulse : phase pulses
//   frame_start         : high at phase 0 while running
//   busy                : high in RUN and STOP_PEND
//   frame_count         : completed frames, wrapping
module pulse_scheduler #(
    parameter int CNT_W  = 4,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              single,
    pulse_scheduler_if.slave  cfg,
    output logic              Data_Out_pulse,
    output logic              Set_Data_out_pulse,
    output logic              State_Out_pulse,
    output logic              frame_start,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_count
);
    typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] sh_last, sh_data, sh_set, sh_state;
    logic [CNT_W-1:0] act_last, act_data, act_set, act_state;
    logic one_shot, wrap, cfg_wr, commit;

    assign busy   = state != IDLE;
    assign wrap   = busy && phase == act_last;
    // Shadow is frozen during the commit cycle so the copy is never torn.
    assign cfg.cfg_ready = !wrap;
    assign cfg_wr = cfg.cfg_valid && cfg.cfg_ready;
    assign commit = !busy || wrap;

    assign frame_start        = busy && phase == '0;
    assign Data_Out_pulse     = busy && phase == act_data;
    assign Set_Data_out_pulse = busy && phase == act_set;
    assign State_Out_pulse    = busy && phase == act_state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = (start && !stop) ? RUN : IDLE;
            // A stop seen on the last phase ends the frame right there.
            RUN:       state_nx = (stop || one_shot) ? (wrap ? IDLE : STOP_PEND) : RUN;
            STOP_PEND: state_nx = start ? RUN : (wrap ? IDLE : STOP_PEND);
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= '0;
            one_shot    <= 1'b0;
            frame_count <= '0;
            sh_last     <= CNT_W'(10);
            sh_data     <= CNT_W'(2);
            sh_set      <= CNT_W'(4);
            sh_state    <= CNT_W'(6);
            act_last    <= CNT_W'(10);
            act_data    <= CNT_W'(2);
            act_set     <= CNT_W'(4);
            act_state   <= CNT_W'(6);
        end else begin
            phase <= commit ? '0 : phase + CNT_W'(1);
            if (state == IDLE && start && !stop)
                one_shot <= single;
            else if (state == STOP_PEND && start)
                one_shot <= 1'b0;
            if (wrap)
                frame_count <= frame_count + FCNT_W'(1);
            if (cfg_wr) begin
                case (cfg.cfg_addr)
                    2'd0:    sh_last  <= (cfg.cfg_data == '0) ? CNT_W'(1) : cfg.cfg_data;
                    2'd1:    sh_data  <= cfg.cfg_data;
                    2'd2:    sh_set   <= cfg.cfg_data;
                    default: sh_state <= cfg.cfg_data;
                endcase
            end
            if (commit) begin
                act_last  <= sh_last;
                act_data  <= sh_data;
                act_set   <= sh_set;
                act_state <= sh_state;
            end
        end
    end
endmodule

// File: tb/tb_pulse_scheduler.sv
// tb_pulse_scheduler: directed self-checking bench for pulse_scheduler.
//   Drives clk/rst/start/stop/single and the cfg bus; checks all outputs.
module tb_pulse_scheduler;
    localparam int CNT_W  = 4;
    localparam int FCNT_W = 8;

    logic clk = 1'b0;
    logic rst, start, stop, single;
    logic d, s, st, fs, busy;
    logic [FCNT_W-1:0] fc;
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    pulse_scheduler_if #(.CNT_W(CNT_W)) cfg_if();

    pulse_scheduler #(.CNT_W(CNT_W), .FCNT_W(FCNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .single(single),
        .cfg(cfg_if),
        .Data_Out_pulse(d), .Set_Data_out_pulse(s), .State_Out_pulse(st),
        .frame_start(fs), .busy(busy), .frame_count(fc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic start, stop, single;
        logic busy, fs, d, s, st, ready;
        int fc;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; single = 0;
        cfg_if.cfg_valid = 0; cfg_if.cfg_addr = 0; cfg_if.cfg_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [CNT_W-1:0] v);
        cfg_if.cfg_valid = 1; cfg_if.cfg_addr = a; cfg_if.cfg_data = v;
        step();
        cfg_if.cfg_valid = 0;
    endtask

    // After go(), cyc==0 is the first phase-0 cycle of RUN.
    task automatic go();
        start = 1;
        step();
        start = 0;
        single = 0;
        cyc = 0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        int nb, nd, ns, nst, gap;
        vecs[0]  = '{1,0,0, 1,1,0,0,0,1, 0};
        vecs[1]  = '{0,0,0, 1,0,1,1,0,1, 0};
        vecs[2]  = '{0,0,0, 1,0,0,0,0,1, 0};
        vecs[3]  = '{0,0,0, 1,0,0,0,0,0, 0};
        vecs[4]  = '{0,0,0, 1,1,0,0,0,1, 1};
        vecs[5]  = '{0,1,0, 1,0,1,1,0,1, 1};
        vecs[6]  = '{0,0,0, 1,0,0,0,0,1, 1};
        vecs[7]  = '{0,0,0, 1,0,0,0,0,0, 1};
        vecs[8]  = '{0,0,0, 0,0,0,0,0,1, 2};
        vecs[9]  = '{1,1,0, 0,0,0,0,0,1, 2};
        vecs[10] = '{1,0,1, 1,1,0,0,0,1, 2};
        vecs[11] = '{0,0,0, 1,0,1,1,0,1, 2};
        vecs[12] = '{0,0,0, 1,0,0,0,0,1, 2};
        vecs[13] = '{0,0,0, 1,0,0,0,0,0, 2};
        vecs[14] = '{0,0,0, 0,0,0,0,0,1, 3};

        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_fs", fs, 0);
        chk("rst_pulses", {d, s, st}, 0);
        chk("rst_fc", fc, 0);
        chk("rst_ready", cfg_if.cfg_ready, 1);

        // Table: LAST=3, DATA=SET=1 (coincident), STATE=5 (beyond LAST).
        cfg_write(0, 3);
        cfg_write(1, 1);
        cfg_write(2, 1);
        cfg_write(3, 5);
        step();
        foreach (vecs[i]) begin
            start = vecs[i].start; stop = vecs[i].stop; single = vecs[i].single;
            step();
            start = 0; stop = 0; single = 0;
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d_fs", i), fs, vecs[i].fs);
            chk($sformatf("vec%0d_data", i), d, vecs[i].d);
            chk($sformatf("vec%0d_set", i), s, vecs[i].s);
            chk($sformatf("vec%0d_state", i), st, vecs[i].st);
            chk($sformatf("vec%0d_ready", i), cfg_if.cfg_ready, vecs[i].ready);
            chk($sformatf("vec%0d_fc", i), fc, vecs[i].fc);
        end

        // Default config: period 11, pulses at 2/4/6, three frames.
        do_reset();
        go();
        for (int i = 0; i < 33; i++) begin
            chk($sformatf("def_fs_c%0d", i), fs, int'(i % 11 == 0));
            chk($sformatf("def_data_c%0d", i), d, int'(i % 11 == 2));
            chk($sformatf("def_set_c%0d", i), s, int'(i % 11 == 4));
            chk($sformatf("def_state_c%0d", i), st, int'(i % 11 == 6));
            step();
        end
        chk("def_fc3", fc, 3);
        chk("def_busy", busy, 1);

        // Single frame with defaults.
        do_reset();
        single = 1;
        go();
        nb = 0; nd = 0; ns = 0; nst = 0;
        for (int i = 0; i < 20; i++) begin
            nb += int'(busy); nd += int'(d); ns += int'(s); nst += int'(st);
            step();
        end
        chk("single_busy_cycles", nb, 11);
        chk("single_data_cnt", nd, 1);
        chk("single_set_cnt", ns, 1);
        chk("single_state_cnt", nst, 1);
        chk("single_end_busy", busy, 0);
        chk("single_fc", fc, 1);

        // Reset mid-frame beats start and a concurrent cfg write.
        do_reset();
        go();
        step();
        rst = 1; start = 1;
        cfg_if.cfg_valid = 1; cfg_if.cfg_addr = 0; cfg_if.cfg_data = 3;
        step();
        idle_inputs(); rst = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_pulses", {fs, d, s, st}, 0);
        chk("midrst_fc", fc, 0);
        chk("midrst_ready", cfg_if.cfg_ready, 1);
        step();
        go();
        run_to(4);
        chk("midrst_last_kept_c4", fs, 0);
        run_to(11);
        chk("midrst_last_kept_c11", fs, 1);

        // Mid-frame LAST=5 write applies from the next frame.
        do_reset();
        go();
        run_to(3);
        cfg_write(0, 5);
        run_to(10);
        chk("midwr_fs_c10", fs, 0);
        run_to(11);
        chk("midwr_fs_c11", fs, 1);
        chk("midwr_fc_c11", fc, 1);
        run_to(16);
        chk("midwr_fs_c16", fs, 0);
        run_to(17);
        chk("midwr_fs_c17", fs, 1);

        // Write held across the commit cycle is taken one cycle later.
        do_reset();
        go();
        run_to(10);
        chk("commit_ready_low", cfg_if.cfg_ready, 0);
        cfg_if.cfg_valid = 1; cfg_if.cfg_addr = 2; cfg_if.cfg_data = 7;
        step();
        chk("commit_ready_high", cfg_if.cfg_ready, 1);
        step();
        cfg_if.cfg_valid = 0;
        run_to(15);
        chk("commit_set_old_c15", s, 1);
        run_to(26);
        chk("commit_set_old_gone_c26", s, 0);
        run_to(29);
        chk("commit_set_new_c29", s, 1);

        // Stop at phase 4, start again at phase 8: no gap.
        do_reset();
        go();
        run_to(4);
        stop = 1;
        step();
        stop = 0;
        chk("restart_busy_c5", busy, 1);
        run_to(8);
        start = 1;
        step();
        start = 0;
        gap = 0;
        while (cyc < 22) begin
            step();
            gap += int'(!busy);
            if (cyc == 11) begin
                chk("restart_fs_c11", fs, 1);
                chk("restart_fc_c11", fc, 1);
            end
        end
        chk("restart_gap", gap, 0);
        chk("restart_fs_c22", fs, 1);
        chk("restart_fc_c22", fc, 2);

        // STATE_OFS beyond LAST never fires; LAST=0 becomes period 2.
        do_reset();
        cfg_write(3, 12);
        step();
        go();
        nd = 0; nst = 0;
        for (int i = 0; i < 22; i++) begin
            nd += int'(d); nst += int'(st);
            step();
        end
        chk("ofs12_state_cnt", nst, 0);
        chk("ofs12_data_cnt", nd, 2);
        stop = 1;
        step();
        stop = 0;
        for (int k = 0; k < 30 && busy; k++) step();
        chk("stop_drain_busy", busy, 0);
        cfg_write(0, 0);
        step();
        go();
        chk("last0_fs_c0", fs, 1);
        step();
        chk("last0_fs_c1", fs, 0);
        chk("last0_data_c1", d, 0);
        step();
        chk("last0_fs_c2", fs, 1);
        step();
        chk("last0_fs_c3", fs, 0);
        step();
        chk("last0_fs_c4", fs, 1);
        chk("last0_busy", busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
